// File: rtl/uart_baud_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen_pkg
// Description : Shared widths, constants and helpers for the fractional
//               UART baud-rate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_baud_gen_pkg;

  localparam int BAUD_W     = 13;  // integer divisor / period counter width
  localparam int FRAC_W     = 3;   // fractional divisor width (eighths)
  localparam int OVERSAMPLE = 16;  // oversample ticks per bit
  localparam int TICK_W     = 4;   // width of the oversample tick index

  // Last oversample tick of a bit; the pulse leaving it is the bit-rate pulse.
  localparam logic [TICK_W-1:0] TICK_WRAP = TICK_W'(OVERSAMPLE - 1);

  // Fraction accumulator sum with the carry kept as the top bit.
  typedef logic [FRAC_W:0] frac_sum_t;

  function automatic frac_sum_t frac_add(input logic [FRAC_W-1:0] a,
                                         input logic [FRAC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen_if
// Description : Configuration and enable-pulse bundle between the register
//               wrapper / UART engines (master) and the baud generator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_baud_gen_if #(
  parameter int BAUD_W = uart_baud_gen_pkg::BAUD_W
);
  import uart_baud_gen_pkg::*;

  logic                baud_en;
  logic [BAUD_W-1:0]   baud_val;
  logic [FRAC_W-1:0]   baud_val_fraction;
  logic                baud_clock;
  logic                xmit_pulse;
  logic [TICK_W-1:0]   sample_phase;

  modport master (
    output baud_en, baud_val, baud_val_fraction,
    input  baud_clock, xmit_pulse, sample_phase
  );

  modport slave (
    input  baud_en, baud_val, baud_val_fraction,
    output baud_clock, xmit_pulse, sample_phase
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Fractional baud-rate generator. Emits a one-cycle 16x
//               oversample enable every BAUD_VAL+1 (+1 when stretched) clocks
//               and a bit-rate pulse on every 16th oversample enable.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter bit BAUD_VAL_FRCTN_EN = 1'b0,
  parameter int BAUD_W            = uart_baud_gen_pkg::BAUD_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_baud_gen_if.slave bus_if
);
  import uart_baud_gen_pkg::*;

  logic [FRAC_W-1:0] frac_eff;

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] cfg_val_q, cfg_val_d;
  logic [FRAC_W-1:0] cfg_frac_q, cfg_frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              baud_clk_q, baud_clk_d;
  logic              xmit_q, xmit_d;
  frac_sum_t         acc_sum;
  logic              restart;

  // The fraction can be compiled out; the input is then ignored entirely.
  generate
    if (BAUD_VAL_FRCTN_EN) begin : g_frac_en
      assign frac_eff = bus_if.baud_val_fraction;
    end else begin : g_frac_off
      logic unused_frac;
      assign unused_frac = ^bus_if.baud_val_fraction;
      assign frac_eff    = '0;
    end
  endgenerate

  // Next-state: idle/restart loads, countdown, stretch cycle, or pulse.
  always_comb begin
    cnt_d      = cnt_q;
    cfg_val_d  = cfg_val_q;
    cfg_frac_d = cfg_frac_q;
    acc_d      = acc_q;
    stretch_d  = stretch_q;
    tick_d     = tick_q;
    baud_clk_d = 1'b0;
    xmit_d     = 1'b0;

    acc_sum = frac_add(acc_q, cfg_frac_q);
    restart = (bus_if.baud_val != cfg_val_q) || (frac_eff != cfg_frac_q);

    if (!bus_if.baud_en || restart) begin
      // Same loads as reset so a new period never starts part-way through.
      cnt_d      = bus_if.baud_val;
      cfg_val_d  = bus_if.baud_val;
      cfg_frac_d = frac_eff;
      acc_d      = '0;
      stretch_d  = 1'b0;
      tick_d     = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - BAUD_W'(1);
    end else if (stretch_q) begin
      // Extra cycle inserted after a fractional carry; counter parks at 0.
      stretch_d = 1'b0;
    end else begin
      baud_clk_d = 1'b1;
      cnt_d      = cfg_val_q;
      acc_d      = acc_sum[FRAC_W-1:0];
      stretch_d  = acc_sum[FRAC_W];
      tick_d     = tick_q + TICK_W'(1);
      xmit_d     = (tick_q == TICK_WRAP);
    end
  end

  // State and output registers; reset takes priority over any period state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= bus_if.baud_val;
      cfg_val_q  <= bus_if.baud_val;
      cfg_frac_q <= frac_eff;
      acc_q      <= '0;
      stretch_q  <= 1'b0;
      tick_q     <= '0;
      baud_clk_q <= 1'b0;
      xmit_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cfg_val_q  <= cfg_val_d;
      cfg_frac_q <= cfg_frac_d;
      acc_q      <= acc_d;
      stretch_q  <= stretch_d;
      tick_q     <= tick_d;
      baud_clk_q <= baud_clk_d;
      xmit_q     <= xmit_d;
    end
  end

  assign bus_if.baud_clock   = baud_clk_q;
  assign bus_if.xmit_pulse   = xmit_q;
  assign bus_if.sample_phase = tick_q;

endmodule
`default_nettype wire

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Fractional baud-rate generator sitting directly upstream of the UART transmit and receive engines.
- Consumes the 13-bit integer baud value and the 3-bit fractional baud value produced by the APB register wrapper.
- Produces a single-cycle 16x-oversample enable (BAUD_CLOCK) and a 1x bit-rate enable (XMIT_PULSE) on the system clock.
- No derived clocks: everything runs on CLK.

Parameters:
- BAUD_VAL_FRCTN_EN, 0, 1 = honour BAUD_VAL_FRACTION; 0 = force fraction to 3'b000.
- BAUD_W, 13, width of BAUD_VAL and of the period counter.

Ports:
- CLK  input  1  system clock; single clock domain.
- RESET  input  1  synchronous, active-high reset.
- BAUD_EN  input  1  generator enable; low holds the block idle.
- BAUD_VAL  input  BAUD_W  integer divisor; period = BAUD_VAL+1 CLK cycles.
- BAUD_VAL_FRACTION  input  3  fractional divisor in eighths (0..7).
- BAUD_CLOCK  output  1  one-cycle 16x-oversample enable pulse.
- XMIT_PULSE  output  1  one-cycle pulse on every 16th BAUD_CLOCK.
- SAMPLE_PHASE  output  4  current oversample tick index 0..15.

Interface note (already decided): one clock; reset is synchronous and active-high (CLK, RESET).

Behaviour:
- Internal state:
  - cnt[BAUD_W-1:0] down-counter
  - frac_acc[2:0] accumulator
  - stretch (1 bit)
  - tick[3:0] (drives SAMPLE_PHASE)
  - registered copies cfg_val and cfg_frac of the inputs
- All outputs are registered. Reset values: BAUD_CLOCK=0, XMIT_PULSE=0, SAMPLE_PHASE=0.
- Reset (RESET=1 at a CLK edge):
  - cnt<=BAUD_VAL, frac_acc<=0, stretch<=0, tick<=0
  - cfg_val/cfg_frac <= inputs
  - Reset has priority over everything, including mid-period.
- BAUD_EN=0: same loads as reset, outputs forced 0. Enabling restarts cleanly, with no partial period.
- Restart: if BAUD_EN=1 and (BAUD_VAL!=cfg_val or effective fraction!=cfg_frac):
  - perform the reset loads, update cfg_*
  - no pulse that cycle
  - A new period starts from the next cycle.
- Normal enabled cycle, priority in order:
  - cnt!=0: cnt<=cnt-1; BAUD_CLOCK<=0.
  - cnt==0 and stretch=1: stretch<=0; cnt held at 0; BAUD_CLOCK<=0. This is the extra cycle.
  - cnt==0 and stretch=0: BAUD_CLOCK<=1; cnt<=cfg_val; {carry,frac_acc}<=frac_acc+cfg_frac; stretch<=carry; tick<=tick+1 (wraps 15->0).
    - XMIT_PULSE<=1 in that same cycle iff tick==15 before the increment, otherwise 0.
- Timing:
  - Period between BAUD_CLOCK pulses is cfg_val+1, or cfg_val+2 when stretched.
  - Over 8 pulses exactly cfg_frac periods are stretched, so the average period is cfg_val+1+cfg_frac/8.
  - First BAUD_CLOCK is asserted cfg_val+1 cycles after the first enabled, non-restart cycle.
- Boundary conditions:
  - BAUD_VAL=0, fraction=0: BAUD_CLOCK high every cycle.
  - BAUD_VAL=0 with fraction: a pulse every 1 or 2 cycles.
  - BAUD_VAL max (8191): 13-bit counter, no overflow.
  - frac_acc wraps modulo 8; carry is the 4th bit of the sum.
- Arithmetic: unsigned only; no multiply or divide.

Decomposition:
- Shared package holds:
  - BAUD_W=13
  - FRAC_W=3
  - OVERSAMPLE=16
  - TICK_W=4
  - localparam for tick wrap value 15
- No sub-module. Counter, accumulator and tick logic stay in one module; the fractional accumulator is too small to justify separation.

Test Plan:
- BAUD_VAL=3, F=0, BAUD_EN=1 after reset -> BAUD_CLOCK every 4 cycles, first at cycle 4; XMIT_PULSE every 64 cycles, coincident with the 16th BAUD_CLOCK; SAMPLE_PHASE counts 1..15,0.
- BAUD_VAL=3, F=4, BAUD_VAL_FRCTN_EN=1 -> periods alternate 4,5 (first 4); 8 pulses span 36 cycles. Repeat with BAUD_VAL_FRCTN_EN=0 -> all periods 4.
- BAUD_VAL=3, F=1 -> exactly one period of 5 in every 8 (the 8th); 16 pulses span 66 cycles.
- BAUD_VAL=0, F=0 -> BAUD_CLOCK constantly 1, XMIT_PULSE one cycle in 16.
- BAUD_VAL changes 3->7 mid-period -> no pulse in the change cycle; next pulse 8 cycles later; SAMPLE_PHASE=0 and frac_acc=0 on restart.
- RESET asserted mid-period, and separately BAUD_EN dropped for 5 cycles -> outputs 0 next cycle; after release the first pulse arrives BAUD_VAL+1 cycles later.
